exception_ctrl: RTL and testbench

Precise-exception and ERET sequencer for the MIPS pipeline's CP0 path. It samples the exception flags and the ERET flag of the instruction in MEM, together with the live CP0 Status/Cause/EPC values. It then produces the hardware-side CP0 update (ExcCode, EPC, BadVAddr, BD, EXL set/clear), a pipeline flush window and a PC redirect. It is the producer of the exception-write bundle that the CP0 register file consumes.

---
 rtl/cp0_pkg.sv | 50 +++++
 rtl/exc_prio_enc.sv | 48 ++++
 rtl/exception_ctrl.sv | 165 ++++++++++++++++
 tb/tb_exception_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register addresses, Status/Cause
// field positions and the exception sequencer state encoding.
package cp0_pkg;

   // ExcCode values written into Cause.ExcCode
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   // CP0 register numbers
   localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
   localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_REG_EPC      = 5'd14;

   // Status / Cause field bit positions
   localparam int STATUS_IE    = 0;
   localparam int STATUS_EXL   = 1;
   localparam int STATUS_IM_LO = 8;
   localparam int STATUS_IM_HI = 15;
   localparam int CAUSE_IP_LO  = 8;
   localparam int CAUSE_IP_HI  = 15;

   // Exception sequencer states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COMMIT   = 2'd1,
      ST_FLUSH    = 2'd2,
      ST_REDIRECT = 2'd3
   } exc_state_t;

   // Source of the BadVAddr value for the winning exception
   typedef enum logic [1:0] {
      BV_NONE = 2'd0,
      BV_PC   = 2'd1,
      BV_DATA = 2'd2
   } bv_sel_t;

   // EPC points at the branch when the faulting instruction sits in its delay slot
   function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_ds);
      return in_ds ? (pc - 32'd4) : pc;
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: picks the highest-priority pending cause
// and reports its ExcCode and where BadVAddr should come from.
module exc_prio_enc
   import cp0_pkg::*;
(
   input  logic       int_req,
   input  logic       exc_adel_if,
   input  logic       exc_ri,
   input  logic       exc_ov,
   input  logic       exc_syscall,
   input  logic       exc_break,
   input  logic       exc_adel_ld,
   input  logic       exc_ades,
   output logic       hit,
   output logic [4:0] code,
   output bv_sel_t    badvaddr_sel
);

   // Priority chain, interrupt first, store address error last
   always_comb begin
      hit          = 1'b1;
      code         = EXC_INT;
      badvaddr_sel = BV_NONE;
      if (int_req) begin
         code = EXC_INT;
      end else if (exc_adel_if) begin
         code         = EXC_ADEL;
         badvaddr_sel = BV_PC;
      end else if (exc_ri) begin
         code = EXC_RI;
      end else if (exc_ov) begin
         code = EXC_OV;
      end else if (exc_syscall) begin
         code = EXC_SYS;
      end else if (exc_break) begin
         code = EXC_BP;
      end else if (exc_adel_ld) begin
         code         = EXC_ADEL;
         badvaddr_sel = BV_DATA;
      end else if (exc_ades) begin
         code         = EXC_ADES;
         badvaddr_sel = BV_DATA;
      end else begin
         hit = 1'b0;
      end
   end

endmodule

// File: rtl/exception_ctrl.sv
// Precise-exception / ERET sequencer for the CP0 path. Accepts one event from
// MEM, emits the CP0 write bundle, holds flush, then redirects the PC.
module exception_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_in_delay_slot,
   input  logic [31:0] mem_badaddr,
   input  logic        exc_adel_if,
   input  logic        exc_ri,
   input  logic        exc_ov,
   input  logic        exc_syscall,
   input  logic        exc_break,
   input  logic        exc_adel_ld,
   input  logic        exc_ades,
   input  logic        mem_eret,
   input  logic [31:0] status_data,
   input  logic [31:0] cause_data,
   input  logic [31:0] epc_data,
   output logic        cp0_exc_we,
   output logic [4:0]  cp0_exc_code,
   output logic [31:0] cp0_epc,
   output logic        cp0_bd,
   output logic        cp0_badvaddr_we,
   output logic [31:0] cp0_badvaddr,
   output logic        cp0_exl_set,
   output logic        cp0_exl_clr,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   // Remaining FLUSH-state cycles after COMMIT; zero means COMMIT goes straight to REDIRECT
   localparam logic [3:0] FLUSH_EXTRA = 4'(FLUSH_CYCLES - 1);

   exc_state_t  state;
   logic [3:0]  cnt;
   logic        int_req;
   logic        hit;
   logic [4:0]  code;
   bv_sel_t     bv_sel;
   logic        accept;
   logic [31:0] bv_value;
   logic        unused_bits;

   assign int_req = status_data[STATUS_IE] & ~status_data[STATUS_EXL] &
                    (|(cause_data[CAUSE_IP_HI:CAUSE_IP_LO] &
                       status_data[STATUS_IM_HI:STATUS_IM_LO]));

   assign unused_bits = ^{status_data[31:16], status_data[7:2],
                          cause_data[31:16], cause_data[7:0]};

   exc_prio_enc u_prio (
      .int_req      (int_req),
      .exc_adel_if  (exc_adel_if),
      .exc_ri       (exc_ri),
      .exc_ov       (exc_ov),
      .exc_syscall  (exc_syscall),
      .exc_break    (exc_break),
      .exc_adel_ld  (exc_adel_ld),
      .exc_ades     (exc_ades),
      .hit          (hit),
      .code         (code),
      .badvaddr_sel (bv_sel)
   );

   // Events are only looked at in IDLE; an exception always beats a coincident ERET
   assign accept = (state == ST_IDLE) & mem_valid & (hit | mem_eret);

   // BadVAddr comes from the fetch PC or the data address depending on the cause
   always_comb begin
      bv_value = 32'd0;
      case (bv_sel)
         BV_PC:   bv_value = mem_pc;
         BV_DATA: bv_value = mem_badaddr;
         default: bv_value = 32'd0;
      endcase
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         cnt             <= 4'd0;
         cp0_exc_we      <= 1'b0;
         cp0_exc_code    <= 5'd0;
         cp0_epc         <= 32'd0;
         cp0_bd          <= 1'b0;
         cp0_badvaddr_we <= 1'b0;
         cp0_badvaddr    <= 32'd0;
         cp0_exl_set     <= 1'b0;
         cp0_exl_clr     <= 1'b0;
         flush           <= 1'b0;
         redirect_valid  <= 1'b0;
         redirect_pc     <= 32'd0;
         busy            <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state       <= ST_COMMIT;
                  cnt         <= FLUSH_EXTRA;
                  flush       <= 1'b1;
                  busy        <= 1'b1;
                  cp0_exc_we  <= hit;
                  cp0_exl_set <= hit;
                  cp0_exl_clr <= ~hit;
                  redirect_pc <= hit ? EXC_VECTOR : epc_data;
                  if (hit) begin
                     cp0_exc_code    <= code;
                     cp0_epc         <= epc_of(mem_pc, mem_in_delay_slot);
                     cp0_bd          <= mem_in_delay_slot;
                     cp0_badvaddr_we <= (bv_sel != BV_NONE);
                     if (bv_sel != BV_NONE) begin
                        cp0_badvaddr <= bv_value;
                     end
                  end else begin
                     cp0_badvaddr_we <= 1'b0;
                  end
               end
            end
            ST_COMMIT: begin
               cp0_exc_we      <= 1'b0;
               cp0_exl_set     <= 1'b0;
               cp0_exl_clr     <= 1'b0;
               cp0_badvaddr_we <= 1'b0;
               if (cnt == 4'd0) begin
                  state          <= ST_REDIRECT;
                  flush          <= 1'b0;
                  redirect_valid <= 1'b1;
               end else begin
                  state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (cnt <= 4'd1) begin
                  state          <= ST_REDIRECT;
                  cnt            <= 4'd0;
                  flush          <= 1'b0;
                  redirect_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ST_REDIRECT: begin
               state          <= ST_IDLE;
               cnt            <= 4'd0;
               redirect_valid <= 1'b0;
               busy           <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: stimulus pushes expected commit and
// redirect events, a monitor pops and compares whenever the DUT emits one.
module tb_exception_ctrl;
   import cp0_pkg::*;

   localparam int          FC  = 2;
   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_pc = 32'd0;
   logic        mem_in_delay_slot = 1'b0;
   logic [31:0] mem_badaddr = 32'd0;
   logic        exc_adel_if = 1'b0, exc_ri = 1'b0, exc_ov = 1'b0, exc_syscall = 1'b0;
   logic        exc_break = 1'b0, exc_adel_ld = 1'b0, exc_ades = 1'b0;
   logic        mem_eret = 1'b0;
   logic [31:0] status_data = 32'd0, cause_data = 32'd0, epc_data = 32'd0;
   logic        cp0_exc_we, cp0_bd, cp0_badvaddr_we, cp0_exl_set, cp0_exl_clr;
   logic [4:0]  cp0_exc_code;
   logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;
   logic        flush, redirect_valid, busy;

   exception_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
      .mem_in_delay_slot(mem_in_delay_slot), .mem_badaddr(mem_badaddr),
      .exc_adel_if(exc_adel_if), .exc_ri(exc_ri), .exc_ov(exc_ov),
      .exc_syscall(exc_syscall), .exc_break(exc_break), .exc_adel_ld(exc_adel_ld),
      .exc_ades(exc_ades), .mem_eret(mem_eret), .status_data(status_data),
      .cause_data(cause_data), .epc_data(epc_data), .cp0_exc_we(cp0_exc_we),
      .cp0_exc_code(cp0_exc_code), .cp0_epc(cp0_epc), .cp0_bd(cp0_bd),
      .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr),
      .cp0_exl_set(cp0_exl_set), .cp0_exl_clr(cp0_exl_clr), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_redir;
      bit          exc_we;
      bit          exl_set;
      bit          exl_clr;
      logic [4:0]  code;
      logic [31:0] epc;
      bit          bd;
      bit          bv_we;
      logic [31:0] bv;
      logic [31:0] rpc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic push_exc(input logic [4:0] code, input logic [31:0] epc, input bit bd,
                           input bit bv_we, input logic [31:0] bv);
      exp_t c, r;
      c = '{is_redir: 1'b0, exc_we: 1'b1, exl_set: 1'b1, exl_clr: 1'b0, code: code,
            epc: epc, bd: bd, bv_we: bv_we, bv: bv, rpc: 32'd0};
      r = '{is_redir: 1'b1, exc_we: 1'b0, exl_set: 1'b0, exl_clr: 1'b0, code: 5'd0,
            epc: 32'd0, bd: 1'b0, bv_we: 1'b0, bv: 32'd0, rpc: VEC};
      sb.push_back(c);
      sb.push_back(r);
   endtask

   task automatic push_eret(input logic [31:0] rpc);
      exp_t c, r;
      c = '{is_redir: 1'b0, exc_we: 1'b0, exl_set: 1'b0, exl_clr: 1'b1, code: 5'd0,
            epc: 32'd0, bd: 1'b0, bv_we: 1'b0, bv: 32'd0, rpc: 32'd0};
      r = '{is_redir: 1'b1, exc_we: 1'b0, exl_set: 1'b0, exl_clr: 1'b0, code: 5'd0,
            epc: 32'd0, bd: 1'b0, bv_we: 1'b0, bv: 32'd0, rpc: rpc};
      sb.push_back(c);
      sb.push_back(r);
   endtask

   // flags = {adel_if, ri, ov, sys, brk, adel_ld, ades}; presented for exactly one cycle
   task automatic fire(input logic [6:0] flags, input logic eret, input logic [31:0] pc,
                       input logic ds, input logic [31:0] baddr);
      mem_valid = 1'b1;
      mem_pc = pc;
      mem_in_delay_slot = ds;
      mem_badaddr = baddr;
      {exc_adel_if, exc_ri, exc_ov, exc_syscall, exc_break, exc_adel_ld, exc_ades} = flags;
      mem_eret = eret;
      @(posedge clk); #1;
      mem_valid = 1'b0;
      {exc_adel_if, exc_ri, exc_ov, exc_syscall, exc_break, exc_adel_ld, exc_ades} = 7'd0;
      mem_eret = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 30; i++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   // Monitor state
   exp_t e;
   bit   in_seq = 1'b0;
   bit   post_redir = 1'b0;
   int   cyc = 0;
   int   fcnt = 0;

   // Monitor: sample on the falling edge and compare against the scoreboard head
   always @(negedge clk) begin
      if (rst) begin
         in_seq = 1'b0;
         post_redir = 1'b0;
      end else begin
         if (in_seq) begin
            cyc++;
            if (flush) fcnt++;
         end
         if (post_redir) begin
            chk("busy_drop", {31'd0, busy}, 32'd0);
            post_redir = 1'b0;
         end
         if (cp0_exc_we || cp0_exl_clr || redirect_valid) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event: got we=%b clr=%b redir=%b required none",
                        cp0_exc_we, cp0_exl_clr, redirect_valid);
            end else begin
               e = sb.pop_front();
               if (!e.is_redir) begin
                  chk("redir_in_commit", {31'd0, redirect_valid}, 32'd0);
                  chk("exc_we", {31'd0, cp0_exc_we}, {31'd0, e.exc_we});
                  chk("exl_set", {31'd0, cp0_exl_set}, {31'd0, e.exl_set});
                  chk("exl_clr", {31'd0, cp0_exl_clr}, {31'd0, e.exl_clr});
                  chk("commit_flush", {31'd0, flush}, 32'd1);
                  chk("commit_busy", {31'd0, busy}, 32'd1);
                  if (e.exc_we) begin
                     chk("exc_code", {27'd0, cp0_exc_code}, {27'd0, e.code});
                     chk("epc", cp0_epc, e.epc);
                     chk("bd", {31'd0, cp0_bd}, {31'd0, e.bd});
                     chk("badvaddr_we", {31'd0, cp0_badvaddr_we}, {31'd0, e.bv_we});
                     if (e.bv_we) chk("badvaddr", cp0_badvaddr, e.bv);
                  end
                  in_seq = 1'b1;
                  cyc = 0;
                  fcnt = 1;
               end else begin
                  chk("redirect_valid", {31'd0, redirect_valid}, 32'd1);
                  chk("redirect_pc", redirect_pc, e.rpc);
                  chk("redir_flush", {31'd0, flush}, 32'd0);
                  chk("redir_busy", {31'd0, busy}, 32'd1);
                  chk("redir_latency", cyc, FC);
                  chk("flush_len", fcnt, FC);
                  in_seq = 1'b0;
                  post_redir = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_exc_we", {31'd0, cp0_exc_we}, 32'd0);
      chk("rst_redir", {31'd0, redirect_valid}, 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      chk("rst_epc", cp0_epc, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Overflow, not in delay slot
      push_exc(EXC_OV, 32'h8000_1000, 1'b0, 1'b0, 32'd0);
      fire(7'b0010000, 1'b0, 32'h8000_1000, 1'b0, 32'd0);
      wait_idle();

      // AdES in delay slot
      push_exc(EXC_ADES, 32'h8000_2000, 1'b1, 1'b1, 32'h0000_0003);
      fire(7'b0000001, 1'b0, 32'h8000_2004, 1'b1, 32'h0000_0003);
      wait_idle();

      // Interrupt beats RI
      status_data = 32'h0000_8001;
      cause_data  = 32'h0000_8000;
      push_exc(EXC_INT, 32'h8000_3000, 1'b0, 1'b0, 32'd0);
      fire(7'b0100000, 1'b0, 32'h8000_3000, 1'b0, 32'd0);
      wait_idle();

      // Interrupt masked by EXL: a bare instruction does nothing, RI alone is taken
      status_data = 32'h0000_8003;
      fire(7'b0000000, 1'b0, 32'h8000_3004, 1'b0, 32'd0);
      chk("exl_masks_int", {31'd0, busy}, 32'd0);
      push_exc(EXC_RI, 32'h8000_3004, 1'b0, 1'b0, 32'd0);
      fire(7'b0100000, 1'b0, 32'h8000_3004, 1'b0, 32'd0);
      wait_idle();

      // Pending interrupt without a valid MEM instruction is not taken
      status_data = 32'h0000_8001;
      mem_valid = 1'b0;
      @(posedge clk); #1;
      chk("int_needs_valid", {31'd0, busy}, 32'd0);
      status_data = 32'd0;
      cause_data  = 32'd0;

      // ERET alone, then ERET with Sys
      epc_data = 32'h8000_0180;
      push_eret(32'h8000_0180);
      fire(7'b0000000, 1'b1, 32'h8000_3100, 1'b0, 32'd0);
      wait_idle();
      push_exc(EXC_SYS, 32'h8000_4000, 1'b0, 1'b0, 32'd0);
      fire(7'b0001000, 1'b1, 32'h8000_4000, 1'b0, 32'd0);
      wait_idle();

      // Fetch AdEL beats AdES; BadVAddr is the PC
      push_exc(EXC_ADEL, 32'h8000_5001, 1'b0, 1'b1, 32'h8000_5001);
      fire(7'b1000001, 1'b0, 32'h8000_5001, 1'b0, 32'h0000_1234);
      wait_idle();

      // Break beats data AdEL, then data AdEL alone
      push_exc(EXC_BP, 32'h8000_6000, 1'b0, 1'b0, 32'd0);
      fire(7'b0000110, 1'b0, 32'h8000_6000, 1'b0, 32'h1000_0002);
      wait_idle();
      push_exc(EXC_ADEL, 32'h8000_6004, 1'b0, 1'b1, 32'h1000_0002);
      fire(7'b0000010, 1'b0, 32'h8000_6004, 1'b0, 32'h1000_0002);
      wait_idle();

      // EPC wraps below zero for a delay slot at address 0
      push_exc(EXC_OV, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd0);
      fire(7'b0010000, 1'b0, 32'h0000_0000, 1'b1, 32'd0);
      wait_idle();

      // An exception presented while busy is dropped
      push_exc(EXC_OV, 32'h8000_7000, 1'b0, 1'b0, 32'd0);
      fire(7'b0010000, 1'b0, 32'h8000_7000, 1'b0, 32'd0);
      fire(7'b0001000, 1'b0, 32'h8000_7004, 1'b0, 32'd0);
      wait_idle();
      repeat (4) @(posedge clk);
      #1;

      // Reset during FLUSH: commit seen, redirect never issued
      push_exc(EXC_SYS, 32'h8000_8000, 1'b0, 1'b0, 32'd0);
      void'(sb.pop_back());
      fire(7'b0001000, 1'b0, 32'h8000_8000, 1'b0, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_flush", {31'd0, flush}, 32'd0);
      chk("mid_rst_redir", {31'd0, redirect_valid}, 32'd0);
      chk("mid_rst_epc", cp0_epc, 32'd0);
      chk("mid_rst_rpc", redirect_pc, 32'd0);
      chk("mid_rst_code", {27'd0, cp0_exc_code}, 32'd0);
      repeat (8) @(posedge clk);
      #1;

      chk("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
